// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: instruction fetch front end. It issues word requests, buffers in-order
// responses in a small FIFO, presents them to decode and discards responses made stale by a redirect.
module fetch_unit #(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter int                      FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    req_valid,
  output logic [ADDRESS_BITS-1:0] req_addr,
  input  logic                    req_ready,
  input  logic                    resp_valid,
  input  logic [31:0]             resp_data,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    inst_valid,
  input  logic                    decode_ready
);

  localparam int                      PTR_W = $clog2(FIFO_DEPTH);
  localparam int                      CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]             NOP   = 32'h0000_0013;
  localparam logic [ADDRESS_BITS-1:0] WORD  = ADDRESS_BITS'(4);

  typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_next;

  logic [ADDRESS_BITS-1:0] pc_q, resp_pc, target_word;
  logic [CNT_W-1:0]        outstanding, outstanding_next, discard, count;
  logic [CNT_W:0]          in_use;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [ADDRESS_BITS-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]             fifo_data [FIFO_DEPTH];
  logic                    issue, resp_ok, drop, push, pop, redirect;
  logic                    unused_target_bits;

  assign unused_target_bits = ^target_PC[1:0];

  // Occupancy plus in-flight requests bounds issue, so a response always has a free slot.
  assign in_use = {1'b0, outstanding} + {1'b0, count};

  always_ff @(posedge clock) begin
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     req_valid  = (in_use < (CNT_W + 1)'(FIFO_DEPTH));
      default: state_next = BOOT;
    endcase
  end

  assign req_addr    = pc_q;
  assign issue       = req_valid && req_ready;
  assign resp_ok     = resp_valid && (outstanding != '0);
  assign drop        = resp_ok && (discard != '0);
  assign push        = resp_ok && (discard == '0);
  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && decode_ready;
  assign redirect    = pop && next_PC_select;
  assign target_word = {target_PC[ADDRESS_BITS-1:2], 2'b00};

  always_comb begin
    outstanding_next = outstanding;
    if (issue && !resp_ok)      outstanding_next = outstanding + CNT_W'(1);
    else if (!issue && resp_ok) outstanding_next = outstanding - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (issue) pc_q <= pc_q + WORD;
      if (redirect) begin
        // Everything still in flight, including a request issued this cycle, is stale.
        pc_q    <= target_word;
        resp_pc <= target_word;
        discard <= outstanding_next;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (drop) discard <= discard - CNT_W'(1);
        if (push) begin
          resp_pc <= resp_pc + WORD;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_data[wr_ptr] <= resp_data;
    end
  end

  assign PC          = inst_valid ? fifo_pc[rd_ptr]   : resp_pc;
  assign instruction = inst_valid ? fifo_data[rd_ptr] : NOP;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: randomized fetch/decode traffic against a program-order reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, req_ready, resp_valid, next_PC_select, decode_ready, sel;
  logic [31:0] resp_data;
  logic [15:0] target_PC;

  logic        req_valid_a, req_valid_b, inst_valid_a, inst_valid_b;
  logic [15:0] req_addr_a, req_addr_b, pc_a, pc_b;
  logic [31:0] instruction_a, instruction_b;
  logic        req_valid_m, inst_valid_m;
  logic [15:0] req_addr_m, pc_m;
  logic [31:0] instruction_m;

  always #5 clock = ~clock;

  fetch_unit dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid_a), .req_addr(req_addr_a),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .next_PC_select(next_PC_select), .target_PC(target_PC), .PC(pc_a),
    .instruction(instruction_a), .inst_valid(inst_valid_a), .decode_ready(decode_ready)
  );

  fetch_unit #(.RESET_PC(16'hFFF8)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_addr(req_addr_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .next_PC_select(next_PC_select), .target_PC(target_PC), .PC(pc_b),
    .instruction(instruction_b), .inst_valid(inst_valid_b), .decode_ready(decode_ready)
  );

  assign req_valid_m   = sel ? req_valid_b   : req_valid_a;
  assign req_addr_m    = sel ? req_addr_b    : req_addr_a;
  assign inst_valid_m  = sel ? inst_valid_b  : inst_valid_a;
  assign pc_m          = sel ? pc_b          : pc_a;
  assign instruction_m = sel ? instruction_b : instruction_a;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [15:0] popped[$];
  int          checks = 0, failures = 0;
  int          cyc, n_req, n_pop, first_valid_cyc;
  int          lat_min, lat_max, p_ready, p_dec, p_redir;
  logic [15:0] exp_pc, exp_req, redir_pc, redir_tgt;
  logic        redir_en;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  task automatic set_knobs(input int lmin, input int lmax, input int pr, input int pd, input int px);
    lat_min = lmin; lat_max = lmax; p_ready = pr; p_dec = pd; p_redir = px;
  endtask

  // One cycle: sample at negedge, drive inputs, advance the model for the coming edge.
  task automatic step();
    logic        rv, iv, acc, pop;
    logic [15:0] ra, pc;
    logic [31:0] ins;
    mreq_t       e;
    rv = req_valid_m; ra = req_addr_m; iv = inst_valid_m; pc = pc_m; ins = instruction_m;
    if (!iv) begin
      checks++;
      if (pc !== exp_pc || ins !== NOP) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got PC=%h instr=%h want PC=%h instr=%h", cyc, pc, ins, exp_pc, NOP);
      end
    end else if (first_valid_cyc < 0) first_valid_cyc = cyc;

    req_ready = ($urandom_range(99) < p_ready);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
    decode_ready   = ($urandom_range(99) < p_dec);
    next_PC_select = ($urandom_range(99) < p_redir);
    target_PC      = 16'($urandom);
    if (redir_en && iv && pc == redir_pc) begin
      decode_ready = 1'b1; next_PC_select = 1'b1; target_PC = redir_tgt; redir_en = 1'b0;
    end

    acc = rv && req_ready;
    if (acc) begin
      checks++;
      if (ra !== exp_req) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got %h want %h", cyc, ra, exp_req);
      end
      e.addr = ra;
      e.due  = cyc + $urandom_range(lat_max, lat_min);
      mq.push_back(e);
      exp_req += 16'd4;
      n_req++;
    end

    pop = iv && decode_ready;
    if (pop) begin
      checks++;
      if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL deliver cyc=%0d got PC=%h instr=%h want PC=%h instr=%h", cyc, pc, ins, exp_pc, mem_word(exp_pc));
      end
      popped.push_back(pc);
      n_pop++;
      if (next_PC_select) begin
        exp_pc  = {target_PC[15:2], 2'b00};
        exp_req = exp_pc;
      end else exp_pc += 16'd4;
    end

    checks++;
    if (mq.size() > DEPTH) begin
      failures++;
      $display("FAIL in_flight cyc=%0d got %0d want <=%0d", cyc, mq.size(), DEPTH);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset(input logic s);
    logic [15:0] rpc;
    sel = s; reset = 1'b1;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    decode_ready = 1'b0; next_PC_select = 1'b0; target_PC = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rpc = s ? 16'hFFF8 : 16'h0000;
    mq.delete(); popped.delete();
    exp_pc = rpc; exp_req = rpc; cyc = 0; n_req = 0; n_pop = 0;
    first_valid_cyc = -1; redir_en = 1'b0;
    checks++;
    if (req_valid_m !== 1'b0 || inst_valid_m !== 1'b0 || instruction_m !== NOP || pc_m !== rpc) begin
      failures++;
      $display("FAIL reset_state got rv=%b iv=%b instr=%h PC=%h want 0 0 %h %h",
               req_valid_m, inst_valid_m, instruction_m, pc_m, NOP, rpc);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    set_knobs(1, 1, 0, 0, 0);
    repeat (4) step();
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    set_knobs(1, 1, 100, 100, 0);
    repeat (40) step();
    checks++;
    if (first_valid_cyc != 3) begin
      failures++;
      $display("FAIL first_valid_latency got %0d want 3", first_valid_cyc);
    end
    checks++;
    if (n_pop < 10 || popped[0] !== 16'h0000) begin
      failures++;
      $display("FAIL stream_progress got pops=%0d want >=10 starting at 0000", n_pop);
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    set_knobs(1, 1, 100, 0, 0);
    repeat (10) step();
    checks++;
    if (n_req != DEPTH || inst_valid_m !== 1'b1 || req_valid_m !== 1'b0) begin
      failures++;
      $display("FAIL stall_full got reqs=%0d iv=%b rv=%b want %0d 1 0", n_req, inst_valid_m, req_valid_m, DEPTH);
    end
    set_knobs(1, 1, 100, 100, 0);
    repeat (10) step();
    checks++;
    if (n_pop < 2 || popped[0] !== 16'h0000 || popped[1] !== 16'h0004) begin
      failures++;
      $display("FAIL stall_release got pops=%0d want >=2 in order 0000 0004", n_pop);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    set_knobs(3, 3, 100, 100, 0);
    redir_en = 1'b1; redir_pc = 16'h0008; redir_tgt = 16'h0042;
    repeat (40) step();
    checks++;
    if (redir_en) begin
      failures++;
      $display("FAIL redirect_fired got pending=1 want 0");
    end
    for (int i = 0; i < n_pop; i++) begin
      checks++;
      if (popped[i] === 16'h000C) begin
        failures++;
        $display("FAIL stale_presented got PC=%h at pop %0d want never 000C", popped[i], i);
      end
      if (popped[i] === 16'h0008 && i + 1 < n_pop) begin
        checks++;
        if (popped[i+1] !== 16'h0040) begin
          failures++;
          $display("FAIL redirect_target got %h want 0040", popped[i+1]);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    do_reset(1'b0);
    set_knobs(3, 3, 50, 100, 0);
    for (int i = 0; i < 400 && n_pop < 16; i++) step();
    checks++;
    if (n_pop < 16 || popped[15] !== 16'h003C) begin
      failures++;
      $display("FAIL random_ready got pops=%0d want 16 ending at 003C", n_pop);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [4];
    want[0] = 16'hFFF8; want[1] = 16'hFFFC; want[2] = 16'h0000; want[3] = 16'h0004;
    do_reset(1'b1);
    set_knobs(1, 1, 100, 100, 0);
    for (int i = 0; i < 100 && n_pop < 4; i++) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= n_pop || popped[i] !== want[i]) begin
        failures++;
        $display("FAIL wrap_pc idx=%0d got %h want %h", i, (i < n_pop) ? popped[i] : 16'hxxxx, want[i]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset(1'b0);
    set_knobs(3, 3, 100, 0, 0);
    repeat (5) step();
    do_reset(1'b0);
    set_knobs(1, 1, 100, 100, 0);
    repeat (20) step();
    checks++;
    if (n_pop < 1 || popped[0] !== 16'h0000) begin
      failures++;
      $display("FAIL reset_midop_restart got pops=%0d want first PC 0000", n_pop);
    end
  endtask

  task automatic test_random_traffic();
    do_reset(1'b0);
    set_knobs(1, 4, 70, 60, 15);
    repeat (2000) step();
    checks++;
    if (n_pop < 100) begin
      failures++;
      $display("FAIL random_progress got pops=%0d want >=100", n_pop);
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_random_ready();
    test_wrap();
    test_reset_midop();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
